// File: rtl/iir_pkg.sv
// iir_pkg: shared state encoding and coefficient address map for the biquad IIR loader
package iir_pkg;

    typedef enum logic [1:0] {IDLE, LOADING, PENDING, FLUSH} state_e;

    localparam int NUM_COEFS = 5;

    localparam logic [2:0] ADDR_A1 = 3'd0;
    localparam logic [2:0] ADDR_A2 = 3'd1;
    localparam logic [2:0] ADDR_B0 = 3'd2;
    localparam logic [2:0] ADDR_B1 = 3'd3;
    localparam logic [2:0] ADDR_B2 = 3'd4;

endpackage

// File: rtl/iir_coef_loader_if.sv
// iir_coef_loader_if: write/commit port and active coefficient outputs of the loader
interface iir_coef_loader_if import iir_pkg::*; #(parameter int W = 8);

    logic                 wr_valid;
    logic                 wr_ready;
    logic [2:0]           wr_addr;
    logic [W-1:0]         wr_data;
    logic                 wr_err;
    logic                 commit_req;
    logic                 commit_ack;
    logic                 forced;
    logic                 sample_en;
    logic [NUM_COEFS-1:0] dirty;
    logic [W-1:0]         A1_coef;
    logic [W-1:0]         A2_coef;
    logic [W-1:0]         B0_coef;
    logic [W-1:0]         B1_coef;
    logic [W-1:0]         B2_coef;
    logic                 init_n_out;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req, sample_en,
        input  wr_ready, wr_err, commit_ack, forced, dirty,
        input  A1_coef, A2_coef, B0_coef, B1_coef, B2_coef, init_n_out
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req, sample_en,
        output wr_ready, wr_err, commit_ack, forced, dirty,
        output A1_coef, A2_coef, B0_coef, B1_coef, B2_coef, init_n_out
    );

endinterface

// File: rtl/iir_coef_bank.sv
// iir_coef_bank: one coefficient's shadow register plus the active copy the filter sees
module iir_coef_bank #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val_i,
    input  logic         we_i,
    input  logic [W-1:0] wdata_i,
    input  logic         commit_i,
    output logic [W-1:0] active_o
);

    logic [W-1:0] shadow_q;
    logic [W-1:0] active_q;

    // Writes land in the shadow; only a commit moves the shadow into the active copy
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= rst_val_i;
            active_q <= rst_val_i;
        end else begin
            if (we_i)
                shadow_q <= wdata_i;
            if (commit_i)
                active_q <= shadow_q;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/iir_coef_loader.sv
// iir_coef_loader: shadow/active coefficient loader committing atomically between filter samples
module iir_coef_loader import iir_pkg::*; #(
    parameter int max_coef_width  = 8,
    parameter int frac_coef_width = 4,
    parameter bit init_on_commit  = 1'b1,
    parameter int timeout_cycles  = 255
) (
    input  logic              clk,
    input  logic              rst,
    iir_coef_loader_if.slave  bus
);

    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [max_coef_width-1:0] B0_RST = max_coef_width'(2 ** frac_coef_width);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_COEFS-1:0] dirty_q, dirty_d;
    logic                 wr_ready_q, wr_err_q, ack_q, forced_q, init_n_q;
    logic                 commit, force_c, accept, legal;
    logic [max_coef_width-1:0] coef_w [NUM_COEFS];

    assign accept = bus.wr_valid & wr_ready_q;
    assign legal  = bus.wr_addr < 3'(NUM_COEFS);

    for (genvar i = 0; i < NUM_COEFS; i++) begin : g_bank
        iir_coef_bank #(.W(max_coef_width)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .rst_val_i (3'(i) == ADDR_B0 ? B0_RST : '0),
            .we_i      (accept && bus.wr_addr == 3'(i)),
            .wdata_i   (bus.wr_data),
            .commit_i  (commit),
            .active_o  (coef_w[i])
        );
    end

    // Next state: commit waits for a sample-free cycle unless the timeout counter expires
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        force_c = 1'b0;
        case (state_q)
            IDLE, LOADING: begin
                if (bus.commit_req)
                    state_d = PENDING;
                else if (accept && legal)
                    state_d = LOADING;
            end
            PENDING: begin
                if (!bus.sample_en) begin
                    commit = 1'b1;
                end else if (cnt_q == CW'(timeout_cycles - 1)) begin
                    commit  = 1'b1;
                    force_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (commit) begin
                    state_d = init_on_commit ? FLUSH : IDLE;
                    cnt_d   = '0;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dirty_d = commit ? '0
                : dirty_q | ((accept && legal) ? NUM_COEFS'(1) << bus.wr_addr : '0);
    end

    // State, counter and all handshake outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dirty_q    <= '0;
            wr_ready_q <= 1'b1;
            wr_err_q   <= 1'b0;
            ack_q      <= 1'b0;
            forced_q   <= 1'b0;
            init_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dirty_q    <= dirty_d;
            wr_ready_q <= state_d == IDLE || state_d == LOADING;
            wr_err_q   <= accept && !legal;
            ack_q      <= commit;
            forced_q   <= force_c;
            init_n_q   <= state_q != FLUSH;
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.commit_ack = ack_q;
    assign bus.forced     = forced_q;
    assign bus.dirty      = dirty_q;
    assign bus.init_n_out = init_n_q;
    assign bus.A1_coef    = coef_w[ADDR_A1];
    assign bus.A2_coef    = coef_w[ADDR_A2];
    assign bus.B0_coef    = coef_w[ADDR_B0];
    assign bus.B1_coef    = coef_w[ADDR_B1];
    assign bus.B2_coef    = coef_w[ADDR_B2];

endmodule

// File: tb/tb_iir_coef_loader.sv
// tb_iir_coef_loader: directed stimulus with a commit scoreboard checked by a separate monitor
module tb_iir_coef_loader;
    import iir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    iir_coef_loader_if #(.W(8)) b ();
    iir_coef_loader_if #(.W(8)) b2 ();

    iir_coef_loader #(
        .max_coef_width(8), .frac_coef_width(4), .init_on_commit(1'b1), .timeout_cycles(255)
    ) dut (.clk(clk), .rst(rst), .bus(b));

    iir_coef_loader #(
        .max_coef_width(8), .frac_coef_width(4), .init_on_commit(1'b1), .timeout_cycles(4)
    ) dut_t (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [39:0] c;
        logic        frc;
        int          at;
    } exp_t;

    exp_t        q[$];
    logic [39:0] act;

    assign act = {b.A1_coef, b.A2_coef, b.B0_coef, b.B1_coef, b.B2_coef};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [2:0] a, logic [7:0] d);
        b.wr_valid = 1'b1;
        b.wr_addr  = a;
        b.wr_data  = d;
        tick();
        b.wr_valid = 1'b0;
    endtask

    task automatic commit(logic [39:0] c, logic f, int at_off);
        exp_t e;
        e.c   = c;
        e.frc = f;
        e.at  = at_off < 0 ? -1 : cyc + at_off;
        q.push_back(e);
        b.commit_req = 1'b1;
        tick();
        b.commit_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d acks outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every commit_ack must match the oldest expected commit, then a one-cycle flush
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (b.commit_ack === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got commit_ack=1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("ack_coefs", act, e.c);
                    chk("ack_forced", b.forced, e.frc);
                    chk("ack_dirty", b.dirty, 0);
                    chk("ack_init_n_hi", b.init_n_out, 1);
                    if (e.at >= 0) chk("ack_latency", cyc, e.at);
                    @(negedge clk);
                    chk("flush_init_n_lo", b.init_n_out, 0);
                    @(negedge clk);
                    chk("flush_init_n_hi", b.init_n_out, 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k;
        int n;
        b.wr_valid = 0; b.wr_addr = 0; b.wr_data = 0; b.commit_req = 0; b.sample_en = 0;
        b2.wr_valid = 0; b2.wr_addr = 0; b2.wr_data = 0; b2.commit_req = 0; b2.sample_en = 0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        chk("rst_coefs", act, 40'h00_00_10_00_00);
        chk("rst_wr_ready", b.wr_ready, 1);
        chk("rst_init_n", b.init_n_out, 1);
        chk("rst_dirty", b.dirty, 0);
        chk("rst_wr_err", b.wr_err, 0);
        chk("rst_ack", b.commit_ack, 0);

        wr(ADDR_A1, 8'hF0);
        wr(ADDR_B2, 8'h22);
        chk("dirty_before_commit", b.dirty, 5'b10001);
        chk("not_yet_active", act, 40'h00_00_10_00_00);
        b.sample_en = 1'b0;
        commit(40'hF0_00_10_00_22, 1'b0, 2);
        drain();

        wr(ADDR_B1, 8'h33);
        b.sample_en = 1'b1;
        k = cyc;
        commit(40'hF0_00_10_33_22, 1'b0, 12);
        chk("pending_wr_ready", b.wr_ready, 0);
        for (int i = 0; i < 10; i++) begin
            chk("held_coefs", act, 40'hF0_00_10_00_22);
            tick();
        end
        chk("held_coefs_end", act, 40'hF0_00_10_00_22);
        b.sample_en = 1'b0;
        drain();

        b2.wr_valid = 1'b1;
        b2.wr_addr  = ADDR_A1;
        b2.wr_data  = 8'h11;
        tick();
        b2.wr_valid   = 1'b0;
        b2.sample_en  = 1'b1;
        k = cyc;
        b2.commit_req = 1'b1;
        tick();
        b2.commit_req = 1'b0;
        n = 0;
        while (b2.commit_ack !== 1'b1 && n < 20) begin
            chk("t4_held_a1", b2.A1_coef, 8'h00);
            tick();
            n++;
        end
        chk("t4_ack_cycle", cyc - k, 5);
        chk("t4_forced", b2.forced, 1);
        chk("t4_a1", b2.A1_coef, 8'h11);
        tick();
        chk("t4_forced_pulse", b2.forced, 0);
        chk("t4_init_n_lo", b2.init_n_out, 0);
        b2.sample_en = 1'b0;

        wr(3'd6, 8'h55);
        chk("err_pulse", b.wr_err, 1);
        chk("err_dirty", b.dirty, 0);
        chk("err_coefs", act, 40'hF0_00_10_33_22);
        tick();
        chk("err_one_cycle", b.wr_err, 0);
        commit(40'hF0_00_10_33_22, 1'b0, 2);
        drain();

        b.wr_valid = 1'b1;
        b.wr_addr  = ADDR_A2;
        b.wr_data  = 8'h5A;
        commit(40'hF0_5A_10_33_22, 1'b0, 2);
        b.wr_valid = 1'b0;
        drain();

        wr(ADDR_B0, 8'h7F);
        b.sample_en  = 1'b1;
        b.commit_req = 1'b1;
        tick();
        b.commit_req = 1'b0;
        tick();
        chk("rst_pend_wr_ready", b.wr_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b.sample_en = 1'b0;
        repeat (4) tick();
        chk("rst_pend_coefs", act, 40'h00_00_10_00_00);
        chk("rst_pend_dirty", b.dirty, 0);
        chk("rst_pend_wr_ready2", b.wr_ready, 1);
        chk("rst_pend_init_n", b.init_n_out, 1);
        commit(40'h00_00_10_00_00, 1'b0, 2);
        drain();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iir_coef_loader.md
Name: iir_coef_loader

Overview:
- Upstream control stage for the biquad IIR filter. Owns the five filter coefficients (A1, A2, B0, B1, B2).
- Accepts coefficient writes over a valid/ready port into a shadow bank, then commits them atomically to the active bank. The active bank drives the filter's coefficient inputs.
- Commit happens only in a cycle where the filter's sample enable is low, so the filter never processes a sample with a mixed coefficient set.
- Optionally pulses the filter's active-low init input after each commit to flush the filter state.

Parameters:
- max_coef_width, 8, width of each coefficient in two's complement. Must match the filter's coefficient width.
- frac_coef_width, 4, fractional bits of each coefficient. Used only to form the reset value 1.0 for B0. Legal range 0..max_coef_width-2.
- init_on_commit, 1, 1 = pulse init_n_out low for one cycle after every commit; 0 = init_n_out held high.
- timeout_cycles, 255, maximum number of PENDING cycles with sample_en high before a forced commit. Legal range 1..65535. Counter width is clog2(timeout_cycles+1).

Ports:
- clk, in, 1, clock; all logic is rising-edge.
- rst, in, 1, synchronous active-high reset.
- wr_valid, in, 1, coefficient write request.
- wr_ready, out, 1, loader can accept a write.
- wr_addr, in, 3, coefficient select: 0=A1, 1=A2, 2=B0, 3=B1, 4=B2; 5..7 are illegal.
- wr_data, in, max_coef_width, coefficient value.
- wr_err, out, 1, one-cycle pulse when an illegal address is accepted.
- commit_req, in, 1, request to transfer the shadow bank to the active bank.
- commit_ack, out, 1, one-cycle pulse in the cycle the active bank updates.
- forced, out, 1, one-cycle pulse coincident with commit_ack when the commit was caused by timeout.
- sample_en, in, 1, copy of the enable driven to the filter.
- dirty, out, 5, per-coefficient flag: shadow value written since the last commit. Bit i corresponds to address i.
- A1_coef, A2_coef, B0_coef, B1_coef, B2_coef, out, max_coef_width each, active bank, registered.
- init_n_out, out, 1, active-low flush pulse to the filter's init_n input.

Behaviour:
Reset values (rst high at a clock edge):
- Shadow and active banks: all coefficients 0 except B0 = 2**frac_coef_width (1.0, filter passthrough).
- Outputs: dirty=0, wr_ready=1, wr_err=0, commit_ack=0, forced=0, init_n_out=1.
- State IDLE; timeout counter 0.
- Reset mid-PENDING discards the pending commit. No ack is generated.

FSM states: IDLE, LOADING, PENDING, FLUSH.

IDLE / LOADING:
- wr_ready=1.
- Accepted write (wr_valid & wr_ready) with a legal address: update that shadow register and set its dirty bit. State goes to LOADING.
- Accepted write with an illegal address: no shadow change; wr_err=1 in the next cycle (registered).
- commit_req moves the state to PENDING. A write accepted in the same cycle is included in the commit.
- commit_req in IDLE with dirty=0 is legal. It performs a no-op copy and is still acknowledged.

PENDING:
- wr_ready=0.
- commit_req is ignored.
- If sample_en=0, the commit occurs at this edge:
  - active bank <= shadow bank; dirty <= 0; commit_ack=1 in the next cycle.
  - Next state is FLUSH if init_on_commit=1, else IDLE.
- If sample_en=1, the timeout counter increments.
- When the counter reaches timeout_cycles, the commit is performed regardless of sample_en, with forced=1 alongside commit_ack.
- The counter clears on leaving PENDING.

FLUSH:
- One cycle. init_n_out=0 in the cycle immediately after commit_ack, then the state returns to IDLE.
- wr_ready=0 during FLUSH.

Timing:
- Latency from commit_req (with sample_en=0) to new coefficients visible is 2 edges: one edge to enter PENDING, one edge to commit.
- Active coefficients change only on a commit edge. They never change in a cycle where sample_en was sampled high, except on a forced commit.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package iir_pkg:
  - state enum for IDLE/LOADING/PENDING/FLUSH;
  - coefficient address constants ADDR_A1..ADDR_B2;
  - NUM_COEFS=5.
- The filter wrapper also imports iir_pkg for address constants.
- One sub-module, iir_coef_bank: shadow/active register pair per coefficient with write-enable, commit and reset-value inputs. It is instantiated 5 times.
- The FSM and timeout counter stay in the top module.

Test Plan:
1. Reset, then hold 3 idle cycles -> B0_coef=8'h10, other coefficients 0, wr_ready=1, init_n_out=1, dirty=0.
2. Write A1=8'hF0, B2=8'h22, then commit_req with sample_en=0 ->
   - dirty=5'b10001 before the commit;
   - commit_ack 2 cycles after commit_req, with A1_coef=8'hF0 and B2_coef=8'h22;
   - init_n_out low for exactly the following cycle;
   - dirty=0.
3. commit_req while sample_en is held high for 10 cycles, then low (timeout_cycles=255) -> coefficients unchanged throughout; commit occurs on the first low cycle; forced=0.
4. timeout_cycles=4, sample_en stuck high -> commit_ack and forced both pulse after 4 PENDING cycles.
5. Write to wr_addr=6 -> wr_err pulses once, all shadow and active values unchanged, dirty unchanged.
6. Back-to-back cases:
   - write plus commit_req in the same cycle -> the written value is committed;
   - rst asserted during PENDING -> no commit_ack, and all coefficients return to reset values.
